jump_predict_unit: RTL and testbench

Parametrised successor to the dual-slot decode-stage jump resolver. It decodes `j`/`jal`/`jr`/`jalr` in up to `ISSUE_W` decode slots and selects the first taken jump. It computes that jump's target, maintains a return-address stack (RAS) that predicts `jr $31` when the source operand is not yet forwarded, and registers a single redirect into the E stage. It sits between the D-stage decoders and the fetch PC mux.

---
 rtl/jump_pkg.sv | 25 ++
 rtl/jump_predict_unit_ras.sv | 53 +++++
 rtl/jump_predict_unit.sv | 126 ++++++++++++
 tb/tb_jump_predict_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// jump_pkg: opcode/funct constants, jump kinds and decode helper for the jump predict unit
package jump_pkg;

    localparam logic [5:0]  OP_SPECIAL = 6'b000000;
    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam logic [5:0]  FN_JR      = 6'b001000;
    localparam logic [5:0]  FN_JALR    = 6'b001001;
    localparam logic [31:0] LINK_OFS   = 32'd8;

    typedef enum logic [2:0] {JK_NONE, JK_J, JK_JAL, JK_JR, JK_JALR} jump_kind_e;

    function automatic jump_kind_e decode_jump(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        return op == OP_J       ? JK_J   :
               op == OP_JAL     ? JK_JAL :
               op != OP_SPECIAL ? JK_NONE :
               fn == FN_JR      ? JK_JR  :
               fn == FN_JALR    ? JK_JALR : JK_NONE;
    endfunction

endpackage

// File: rtl/jump_predict_unit_ras.sv
// ras_stack: circular return-address stack with saturating occupancy count
module ras_stack #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eff_pop, wr_en;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign top_idx = ptr_q - PW'(1);
    assign top     = empty ? '0 : mem_q[top_idx];

    // Pop on empty is ignored; push+pop rewrites the top in place; push when full overwrites the oldest
    always_comb begin
        eff_pop = pop && !empty;
        wr_en   = push && !clear;
        wr_idx  = eff_pop ? top_idx : ptr_q;
        ptr_d   = clear ? '0 : (push && !eff_pop) ? ptr_q + PW'(1) : (eff_pop && !push) ? top_idx : ptr_q;
        cnt_d   = clear ? '0 : (push && !eff_pop && !full) ? cnt_q + CW'(1) : (eff_pop && !push) ? cnt_q - CW'(1) : cnt_q;
    end

    // Entry storage has no reset: contents only matter once pushed
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= push_data;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jump_predict_unit.sv
// jump_predict_unit: picks the oldest taken jump in D, computes its target, registers the redirect (RAS prediction under JUMP_RAS_PREDICT_EN)
module jump_predict_unit
    import jump_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int RAS_DEPTH = 8,
    localparam int SW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      stall_d,
    input  logic                      flush_d,
    input  logic                      ras_clear,
    input  logic [ISSUE_W-1:0]        valid_d,
    input  logic [ISSUE_W-1:0][31:0]  instr_d,
    input  logic [ISSUE_W-1:0][31:0]  pc_d,
    input  logic [ISSUE_W-1:0][31:0]  src_d,
    input  logic [ISSUE_W-1:0]        src_ready_d,
    output logic                      jump_e,
    output logic [31:0]               target_e,
    output logic [SW-1:0]             slot_e,
    output logic                      ras_pred_e,
    output logic                      hold_d
);

    logic          win, w_rdy, is_reg, rs31, use_ras, hold, take, unused_ok;
    logic [SW-1:0] win_slot, slot_q, slot_d;
    logic [31:0]   w_instr, w_pc, w_src, pc4, target, target_q, target_d;
    logic          jump_q, jump_d, ras_pred_q, ras_pred_d;
    jump_kind_e    kind;
`ifdef JUMP_RAS_PREDICT_EN
    logic [31:0]   ras_top;
    logic          ras_empty, ras_full, upd, ras_push, ras_pop;
`endif

    // Lowest valid slot holding a jump wins; younger slots are ignored entirely
    always_comb begin
        win      = 1'b0;
        win_slot = '0;
        w_instr  = '0;
        w_pc     = '0;
        w_src    = '0;
        w_rdy    = 1'b0;
        for (int i = ISSUE_W - 1; i >= 0; i--) begin
            if (valid_d[i] && decode_jump(instr_d[i]) != JK_NONE) begin
                win      = 1'b1;
                win_slot = SW'(i);
                w_instr  = instr_d[i];
                w_pc     = pc_d[i];
                w_src    = src_d[i];
                w_rdy    = src_ready_d[i];
            end
        end
    end

    // Target selection for the winner and the stall request when no target is usable
    always_comb begin
        kind   = decode_jump(w_instr);
        is_reg = kind == JK_JR || kind == JK_JALR;
        rs31   = w_instr[25:21] == 5'd31;
        pc4    = w_pc + 32'd4;
`ifdef JUMP_RAS_PREDICT_EN
        use_ras = is_reg && !w_rdy && rs31;
        hold    = is_reg && !w_rdy && (!rs31 || ras_empty);
        target  = use_ras ? ras_top : is_reg ? w_src : {pc4[31:28], w_instr[25:0], 2'b00};
`else
        use_ras = 1'b0;
        hold    = is_reg && !w_rdy;
        target  = is_reg ? w_src : {pc4[31:28], w_instr[25:0], 2'b00};
`endif
        take   = win && !hold;
    end

    assign hold_d = hold;

    // Redirect register next state: flush zeroes, stall holds, otherwise capture the winner
    always_comb begin
        jump_d     = flush_d ? 1'b0 : stall_d ? jump_q : take;
        target_d   = flush_d ? '0 : stall_d ? target_q : take ? target : '0;
        slot_d     = flush_d ? '0 : stall_d ? slot_q : take ? win_slot : '0;
        ras_pred_d = flush_d ? 1'b0 : stall_d ? ras_pred_q : take && use_ras;
    end

    // Redirect registers into E
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            jump_q     <= 1'b0;
            target_q   <= '0;
            slot_q     <= '0;
            ras_pred_q <= 1'b0;
        end else begin
            jump_q     <= jump_d;
            target_q   <= target_d;
            slot_q     <= slot_d;
            ras_pred_q <= ras_pred_d;
        end
    end

    assign jump_e     = jump_q;
    assign target_e   = target_q;
    assign slot_e     = slot_q;
    assign ras_pred_e = ras_pred_q;

`ifdef JUMP_RAS_PREDICT_EN
    assign upd      = take && !flush_d && !stall_d;
    assign ras_push = upd && (kind == JK_JAL || (kind == JK_JALR && w_instr[15:11] == 5'd31));
    assign ras_pop  = upd && is_reg && rs31;

    ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (w_pc + LINK_OFS),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign unused_ok = ^{pc4[27:0], ras_full};
`else
    assign unused_ok = ^{pc4[27:0], ras_clear};
`endif

endmodule

// File: tb/tb_jump_predict_unit.sv
// tb_jump_predict_unit: scoreboard bench for jump_predict_unit; expectations follow JUMP_RAS_PREDICT_EN when defined
module tb_jump_predict_unit;

    localparam int W = 2;
    localparam int D = 8;
    localparam logic [31:0] NOP = 32'h24420001;

    typedef struct packed {
        logic        jump;
        logic [31:0] target;
        logic        slot;
        logic        pred;
    } exp_t;

    logic              clk = 1'b0, resetn = 1'b0, stall_d = 1'b0, flush_d = 1'b0, ras_clear = 1'b0;
    logic [W-1:0]      valid_d = '0, src_ready_d = '0;
    logic [W-1:0][31:0] instr_d = '0, pc_d = '0, src_d = '0;
    logic              jump_e, ras_pred_e, hold_d;
    logic [31:0]       target_e;
    logic [0:0]        slot_e;

    exp_t        sb[$];
    exp_t        last_exp = '0;
    logic [31:0] ras_m[$];
    int          n_total = 0, n_bad = 0;

    always #5 clk = ~clk;

    jump_predict_unit #(.ISSUE_W(W), .RAS_DEPTH(D)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .ras_clear   (ras_clear),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .src_d       (src_d),
        .src_ready_d (src_ready_d),
        .jump_e      (jump_e),
        .target_e    (target_e),
        .slot_e      (slot_e),
        .ras_pred_e  (ras_pred_e),
        .hold_d      (hold_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] f_j(input logic [25:0] idx);
        return {6'b000010, idx};
    endfunction
    function automatic logic [31:0] f_jal(input logic [25:0] idx);
        return {6'b000011, idx};
    endfunction
    function automatic logic [31:0] f_jr(input logic [4:0] rs);
        return {6'b000000, rs, 15'b0, 6'b001000};
    endfunction
    function automatic logic [31:0] f_jalr(input logic [4:0] rs, input logic [4:0] rd);
        return {6'b000000, rs, 5'b0, rd, 5'b0, 6'b001001};
    endfunction
    function automatic logic is_jump(input logic [31:0] ins);
        return ins[31:26] == 6'h02 || ins[31:26] == 6'h03 || (ins[31:26] == 6'h00 && ins[5:1] == 5'b00100);
    endfunction

    // Drive one D-stage cycle, check hold_d, push the expected redirect, then compare after the edge
    task automatic tick(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0,
                        input logic [31:0] s0, input logic [1:0] rdy, input logic st, input logic fl, input logic cl);
        logic        found, hold, pred, take, isreg, rs31, rd31;
        int          ws;
        logic [31:0] wi, wp, wp4, tgt;
        exp_t        e, g;
        valid_d = v; instr_d[0] = i0; instr_d[1] = i1; pc_d[0] = p0; pc_d[1] = p0 + 32'd4;
        src_d[0] = s0; src_d[1] = s0; src_ready_d = rdy; stall_d = st; flush_d = fl; ras_clear = cl;
        #1;
        found = 1'b0; ws = 0;
        for (int s = 0; s < W; s++) if (!found && v[s] && is_jump(instr_d[s])) begin found = 1'b1; ws = s; end
        wi = instr_d[ws]; wp = pc_d[ws]; wp4 = wp + 32'd4;
        isreg = wi[31:26] == 6'h00; rs31 = wi[25:21] == 5'd31; rd31 = wi[15:11] == 5'd31;
        hold = 1'b0; pred = 1'b0; tgt = '0;
        if (found) begin
            if (!isreg) tgt = {wp4[31:28], wi[25:0], 2'b00};
            else if (rdy[ws]) tgt = src_d[ws];
`ifdef JUMP_RAS_PREDICT_EN
            else if (rs31 && ras_m.size() > 0) begin tgt = ras_m[$]; pred = 1'b1; end
`endif
            else hold = 1'b1;
        end
        check("hold_d", hold_d, hold);
        take = found && !hold;
        if (fl) e = '0;
        else if (st) e = last_exp;
        else begin
            e.jump = take; e.target = take ? tgt : '0; e.slot = take ? ws[0] : 1'b0; e.pred = take && pred;
        end
        last_exp = e;
        sb.push_back(e);
`ifdef JUMP_RAS_PREDICT_EN
        if (cl) ras_m.delete();
        else if (!fl && !st && take) begin
            if (isreg && rs31 && ras_m.size() > 0) void'(ras_m.pop_back());
            if (wi[31:26] == 6'h03 || (isreg && wi[0] && rd31)) begin
                ras_m.push_back(wp + 32'd8);
                if (ras_m.size() > D) void'(ras_m.pop_front());
            end
        end
`else
        if (rd31 && cl) ras_m.delete();
`endif
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("jump_e", jump_e, g.jump);
        check("target_e", target_e, g.target);
        check("slot_e", slot_e, g.slot);
        check("ras_pred_e", ras_pred_e, g.pred);
    endtask

    initial begin
        #12;
        check("rst_jump", jump_e, 0);
        check("rst_target", target_e, 0);
        check("rst_slot", slot_e, 0);
        check("rst_pred", ras_pred_e, 0);
        @(negedge clk);
        resetn = 1'b1;
        // jal with a jal in its delay slot: only slot 0 counts
        tick(2'b11, 32'h0C000040, f_jal(26'h3), 32'h00400000, 0, 2'b00, 0, 0, 0);
        check("jal_target", target_e, 32'h00000100);
        tick(2'b01, f_jr(31), NOP, 32'h00400100, 0, 2'b00, 0, 0, 0);
`ifdef JUMP_RAS_PREDICT_EN
        check("ras_return", target_e, 32'h00400008);
        check("ras_pred_set", ras_pred_e, 1);
`endif
        tick(2'b01, f_jr(31), NOP, 32'h00400200, 0, 2'b00, 0, 0, 0);
        // non-jump in slot 0, j in slot 1 across the 0x9 region boundary
        instr_d[1] = f_j(26'h10);
        tick(2'b11, NOP, f_j(26'h10), 32'h8FFFFFF8, 0, 2'b00, 0, 0, 0);
        check("j_slot1", slot_e, 1);
        check("j_nibble", target_e[31:28], 4'h9);
        tick(2'b10, f_jal(26'h7), f_j(26'h20), 32'h00001000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jr(5), NOP, 32'h00002000, 32'h00001234, 2'b01, 0, 0, 0);
        tick(2'b00, NOP, NOP, 32'h00002100, 0, 2'b00, 0, 0, 0);
        // nine calls then nine returns: LIFO with the oldest link overwritten
        for (int k = 0; k < 9; k++) tick(2'b01, f_jal(26'h100 + 26'(k)), NOP, 32'h00010000 + 32'(k * 16), 0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(2'b01, f_jr(31), NOP, 32'h00020000, 0, 2'b00, 0, 0, 0);
`ifdef JUMP_RAS_PREDICT_EN
            check("lifo", target_e, 32'h00010088 - 32'(k * 16));
`endif
        end
        tick(2'b01, f_jr(31), NOP, 32'h00020000, 0, 2'b00, 0, 0, 0);
        // stall holds outputs and blocks pushes, flush zeroes
        tick(2'b01, f_j(26'h200), NOP, 32'h00400100, 0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(2'b01, f_jal(26'h55), NOP, 32'h00030000, 0, 2'b00, 1, 0, 0);
        check("stall_held", target_e, 32'h00000800);
        tick(2'b01, f_jal(26'h55), NOP, 32'h00030000, 0, 2'b00, 0, 1, 0);
        tick(2'b01, f_jr(31), NOP, 32'h00030100, 0, 2'b00, 0, 0, 0);
        // push dropped by ras_clear
        tick(2'b01, f_jal(26'h66), NOP, 32'h00040000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jal(26'h67), NOP, 32'h00040100, 0, 2'b00, 0, 0, 1);
        tick(2'b01, f_jr(31), NOP, 32'h00040200, 0, 2'b00, 0, 0, 0);
        // jalr $31,$31 replaces the top; unready non-$31 register jump holds
        tick(2'b01, f_jal(26'h70), NOP, 32'h00500000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jalr(31, 31), NOP, 32'h00600000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jr(31), NOP, 32'h00700000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jr(31), NOP, 32'h00700100, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jr(7), NOP, 32'h00700200, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jalr(4, 31), NOP, 32'h00800000, 32'hABCDEF00, 2'b01, 0, 0, 0);
        tick(2'b01, f_jr(31), NOP, 32'h00800100, 32'h00001111, 2'b01, 0, 0, 0);
        // asynchronous reset mid-burst
        tick(2'b01, f_jal(26'h80), NOP, 32'h00900000, 0, 2'b00, 0, 0, 0);
        instr_d[0] = f_jal(26'h81);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_jump", jump_e, 0);
        check("arst_target", target_e, 0);
        check("arst_slot", slot_e, 0);
        check("arst_pred", ras_pred_e, 0);
        ras_m.delete();
        sb.delete();
        last_exp = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick(2'b01, f_jr(31), NOP, 32'h00A00000, 0, 2'b00, 0, 0, 0);
        tick(2'b01, f_jal(26'h90), NOP, 32'h00A00100, 0, 2'b00, 0, 0, 0);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
